// File: rtl/systolic_pkg.sv
// Shared types for the systolic result drain: FSM state encoding.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/systolic_idx_counter.sv
// Element index counter for the drain: synchronous clear, increment enable,
// terminal-count flag. Wraps naturally because depth is a power of two.
module systolic_idx_counter #(
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(depth)-1:0] idx,
  output logic                     tc
);
  localparam int IW = $clog2(depth);
  localparam logic [IW-1:0] LAST_IDX = IW'(depth - 1);

  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;
  assign tc  = (idx_q == LAST_IDX);

endmodule

// File: rtl/systolic_result_drain.sv
// Drains a size x size result array row-major through a single-register
// valid/ready output stage. Optional build macro: SYSTOLIC_DRAIN_RELU_EN.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int size  = 4,
  parameter int nbits = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_val,
  output logic                    start_rdy,
  output logic [$clog2(size)-1:0] out_rsel,
  output logic [$clog2(size)-1:0] out_csel,
  input  logic [nbits-1:0]        b_s_in,
  output logic [nbits-1:0]        send_msg,
  output logic                    send_val,
  input  logic                    send_rdy,
  output logic                    send_last,
  output logic                    busy
);
  localparam int SW = $clog2(size);
  localparam int IW = $clog2(size * size);

  drain_state_e     state_q, state_d;
  logic [nbits-1:0] send_msg_q, send_msg_d;
  logic             send_val_q, send_val_d;
  logic             send_last_q, send_last_d;

  logic [IW-1:0]    idx;
  logic             idx_tc;
  logic             start_fire;
  logic             capture;
  logic             fire;
  logic [nbits-1:0] cap_val;

  assign start_fire = (state_q == IDLE) && start_val;
  assign fire       = send_val_q && send_rdy;
  // The register is refilled in the same cycle it drains, giving one word per cycle.
  assign capture    = (state_q == DRAIN) && (!send_val_q || send_rdy);

`ifdef SYSTOLIC_DRAIN_RELU_EN
  assign cap_val = b_s_in[nbits-1] ? '0 : b_s_in;
`else
  assign cap_val = b_s_in;
`endif

  systolic_idx_counter #(
    .depth(size * size)
  ) u_idx (
    .clk(clk),
    .rst(rst),
    .clr(start_fire),
    .inc(capture),
    .idx(idx),
    .tc (idx_tc)
  );

  always_comb begin
    state_d     = state_q;
    send_msg_d  = send_msg_q;
    send_val_d  = send_val_q;
    send_last_d = send_last_q;
    case (state_q)
      IDLE: begin
        if (start_val) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (capture) begin
          send_msg_d  = cap_val;
          send_val_d  = 1'b1;
          send_last_d = idx_tc;
          if (idx_tc) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (fire) begin
          send_val_d  = 1'b0;
          send_last_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      send_msg_q  <= '0;
      send_val_q  <= 1'b0;
      send_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      send_msg_q  <= send_msg_d;
      send_val_q  <= send_val_d;
      send_last_q <= send_last_d;
    end
  end

  assign start_rdy = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign send_msg  = send_msg_q;
  assign send_val  = send_val_q;
  assign send_last = send_last_q;
  // Row-major split of the flat index; forced to zero while idle.
  assign out_rsel  = (state_q == IDLE) ? '0 : idx[IW-1:SW];
  assign out_csel  = (state_q == IDLE) ? '0 : idx[SW-1:0];

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed and table-driven bench for systolic_result_drain (size=4, nbits=16).
module tb_systolic_result_drain;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_val;
  logic        start_rdy;
  logic [1:0]  out_rsel;
  logic [1:0]  out_csel;
  logic [15:0] b_s_in;
  logic [15:0] send_msg;
  logic        send_val;
  logic        send_rdy;
  logic        send_last;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [16];
  logic [16:0] words [$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_msg   = '0;
  logic        prev_last  = 1'b0;

  always #5 clk = ~clk;

  assign b_s_in = mem[{out_rsel, out_csel}];

  systolic_result_drain #(.size(4), .nbits(16)) dut (
    .clk(clk), .rst(rst), .start_val(start_val), .start_rdy(start_rdy),
    .out_rsel(out_rsel), .out_csel(out_csel), .b_s_in(b_s_in),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .send_last(send_last), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int k);
    logic [15:0] v;
    v = mem[k];
`ifdef SYSTOLIC_DRAIN_RELU_EN
    if (v[15]) v = 16'h0000;
`endif
    return v;
  endfunction

  task automatic fill_default();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mem[r*4+c] = 16'(16*r + c);
  endtask

  // Fired words are collected on the falling edge; inputs and outputs are stable then.
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        check("hold_val", 32'(send_val), 32'd1);
        check("hold_msg", 32'(send_msg), 32'(prev_msg));
        check("hold_last", 32'(send_last), 32'(prev_last));
      end
      if (send_val && send_rdy) words.push_back({send_last, send_msg});
      prev_stall = send_val && !send_rdy;
      prev_msg   = send_msg;
      prev_last  = send_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic check_words(input string name);
    check({name, "_count"}, 32'(words.size()), 32'd16);
    for (int k = 0; k < 16 && k < words.size(); k++) begin
      check($sformatf("%s_w%0d", name, k), 32'(words[k][15:0]), 32'(exp_word(k)));
      check($sformatf("%s_last%0d", name, k), 32'(words[k][16]), 32'(k == 15));
    end
    $display("drain %s: %0d words, first %0h", name, words.size(),
             (words.size() > 0) ? words[0][15:0] : 16'h0);
  endtask

  task automatic do_drain(input string name, input bit rand_rdy);
    int n;
    words.delete();
    start_val = 1'b1;
    send_rdy  = 1'b1;
    @(posedge clk); #1;
    start_val = 1'b0;
    n = 0;
    while (busy && n < 500) begin
      send_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    send_rdy = 1'b1;
    check({name, "_timeout"}, 32'(busy), 32'd0);
    check_words(name);
  endtask

  typedef struct {
    logic        sv;
    logic        rdy;
    logic        e_val;
    logic [15:0] e_msg;
    logic        e_last;
    logic        e_busy;
    logic        e_srdy;
  } vec_t;

  vec_t vecs [18];

  initial begin
    // Vector i: inputs applied before edge E_i, outputs expected after it.
    vecs[0] = '{sv: 1'b1, rdy: 1'b1, e_val: 1'b0, e_msg: 16'h0000, e_last: 1'b0, e_busy: 1'b1, e_srdy: 1'b0};
    for (int k = 0; k < 16; k++)
      vecs[k+1] = '{sv: 1'b0, rdy: 1'b1, e_val: 1'b1, e_msg: 16'(16*(k/4) + (k%4)),
                    e_last: (k == 15), e_busy: 1'b1, e_srdy: 1'b0};
    vecs[17] = '{sv: 1'b0, rdy: 1'b1, e_val: 1'b0, e_msg: 16'd51, e_last: 1'b0, e_busy: 1'b0, e_srdy: 1'b1};

    fill_default();
    rst = 1'b0; start_val = 1'b0; send_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_rdy", 32'(start_rdy), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_send_val", 32'(send_val), 32'd0);
    check("rst_send_msg", 32'(send_msg), 32'd0);
    check("rst_send_last", 32'(send_last), 32'd0);
    check("rst_rsel", 32'(out_rsel), 32'd0);
    check("rst_csel", 32'(out_csel), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back drain at full rate.
    for (int i = 0; i < 18; i++) begin
      start_val = vecs[i].sv;
      send_rdy  = vecs[i].rdy;
      @(posedge clk); #1;
      start_val = 1'b0;
      check($sformatf("vec%0d_val", i), 32'(send_val), 32'(vecs[i].e_val));
      if (vecs[i].e_val) begin
        check($sformatf("vec%0d_msg", i), 32'(send_msg), 32'(vecs[i].e_msg));
        check($sformatf("vec%0d_last", i), 32'(send_last), 32'(vecs[i].e_last));
      end
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_srdy", i), 32'(start_rdy), 32'(vecs[i].e_srdy));
      $display("vec %0d: val=%0b msg=%0h last=%0b busy=%0b", i, send_val, send_msg, send_last, busy);
    end

    // Back-pressure while word 5 (value 17) is presented.
    words.delete();
    start_val = 1'b1; send_rdy = 1'b1;
    @(posedge clk); #1;
    start_val = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("stall_pre_val", 32'(send_val), 32'd1);
    check("stall_pre_msg", 32'(send_msg), 32'd17);
    send_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_msg", i), 32'(send_msg), 32'd17);
      check($sformatf("stall%0d_val", i), 32'(send_val), 32'd1);
      check($sformatf("stall%0d_rsel", i), 32'(out_rsel), 32'd1);
      check($sformatf("stall%0d_csel", i), 32'(out_csel), 32'd2);
    end
    send_rdy = 1'b1;
    wait_idle("stall");
    check_words("stall");

    // Start requests during a drain are ignored.
    words.delete();
    start_val = 1'b1;
    @(posedge clk); #1;
    start_val = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy_srdy%0d", i), 32'(start_rdy), 32'd0);
      @(posedge clk); #1;
    end
    start_val = 1'b0;
    wait_idle("ignore");
    check_words("ignore");
    repeat (3) @(posedge clk);
    #1;
    check("no_queued_start", 32'(busy), 32'd0);
    do_drain("second", 1'b0);

    // Asynchronous reset mid-drain, after word 7 is presented.
    words.delete();
    start_val = 1'b1;
    @(posedge clk); #1;
    start_val = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_msg", 32'(send_msg), 32'd19);
    rst = 1'b0;
    #1;
    check("mid_rst_val", 32'(send_val), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_msg", 32'(send_msg), 32'd0);
    check("mid_rst_last", 32'(send_last), 32'd0);
    check("mid_rst_rsel", 32'(out_rsel), 32'd0);
    check("mid_rst_csel", 32'(out_csel), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_srdy", 32'(start_rdy), 32'd1);
    do_drain("after_rst", 1'b0);

    // Negative element: clamped only in the rectified build.
    mem[0] = 16'hFFF0;
    mem[1] = 16'h0005;
    do_drain("relu", 1'b0);
    if (words.size() >= 2) begin
`ifdef SYSTOLIC_DRAIN_RELU_EN
      check("relu_w0", 32'(words[0][15:0]), 32'h0000);
`else
      check("relu_w0", 32'(words[0][15:0]), 32'hFFF0);
`endif
      check("relu_w1", 32'(words[1][15:0]), 32'h0005);
    end else begin
      check("relu_count", 32'(words.size()), 32'd16);
    end
    fill_default();

    // Random downstream back-pressure.
    for (int d = 0; d < 100; d++) begin
      do_drain($sformatf("rand%0d", d), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
